// File: rtl/riscv_lsu_pkg.sv
// Shared types and funct3 encodings for the riscv_lsu load/store unit.
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_D  = 3'b011;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [2:0] LSU_WU = 3'b110;

  function automatic int lsu_size_bytes(input logic [2:0] funct3);
    return 1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane alignment: store strobe/data shift, load extract/extend, fault detection.
// LSU_MISALIGN_TRAP_EN: when defined, misaligned requests are reported as faults.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                          st_we,
  input  logic [2:0]                    st_funct3,
  input  logic [XLEN-1:0]               st_addr,
  input  logic [XLEN-1:0]               st_wdata,
  output logic [XLEN/8-1:0]             st_wstrb,
  output logic [XLEN-1:0]               st_wdata_sh,
  output logic                          st_fault,
  input  logic [2:0]                    ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0]     ld_off,
  input  logic [XLEN-1:0]               ld_rdata,
  output logic [XLEN-1:0]               ld_result
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [OW-1:0]   st_off;
  logic [15:0]     strb_wide;
  logic [XLEN-1:0] ld_shifted;
  logic            ld_sign;
  logic            ld_ext;
  int              st_size;
  int              ld_size;

  assign st_off = st_addr[OW-1:0];

  always_comb begin
    st_size     = lsu_size_bytes(st_funct3);
    // Widen before shifting so lanes past the word are dropped by truncation.
    strb_wide   = (16'(1) << st_size) - 16'd1;
    strb_wide   = strb_wide << st_off;
    st_wstrb    = strb_wide[NB-1:0];
    st_wdata_sh = st_wdata << {st_off, 3'b000};
    st_fault    = (st_size > NB) || (st_we && st_funct3[2]) || (st_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((st_off & OW'(st_size - 1)) != '0) st_fault = 1'b1;
`endif
  end

  always_comb begin
    ld_size    = lsu_size_bytes(ld_funct3);
    ld_shifted = ld_rdata >> {ld_off, 3'b000};
    ld_sign    = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == 8 * ld_size - 1) ld_sign = ld_shifted[i];
    end
    ld_ext = ld_sign & ~ld_funct3[2];
    for (int i = 0; i < XLEN; i++) begin
      ld_result[i] = (i / 8 < ld_size) ? ld_shifted[i] : ld_ext;
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: registered valid/ready memory handshake with IDLE/REQ/WAIT FSM.
// LSU_MISALIGN_TRAP_EN (see riscv_lsu_align) turns misaligned accesses into faults.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              fault,
  output logic [XLEN-1:0]   fault_addr,
  output logic              stall
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_t        state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [OW-1:0]     off_q, off_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   fault_addr_q, fault_addr_d;

  logic [NB-1:0]     st_wstrb;
  logic [XLEN-1:0]   st_wdata_sh;
  logic              st_fault;
  logic [XLEN-1:0]   ld_result;

  riscv_lsu_align #(.XLEN(XLEN)) u_align (
    .st_we       (req_we),
    .st_funct3   (req_funct3),
    .st_addr     (req_addr),
    .st_wdata    (req_wdata),
    .st_wstrb    (st_wstrb),
    .st_wdata_sh (st_wdata_sh),
    .st_fault    (st_fault),
    .ld_funct3   (funct3_q),
    .ld_off      (off_q),
    .ld_rdata    (mem_rdata),
    .ld_result   (ld_result)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    off_d        = off_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (st_fault) begin
            fault_d      = 1'b1;
            fault_addr_d = req_addr;
          end else begin
            state_d  = REQ;
            addr_d   = {req_addr[XLEN-1:OW], OW'(0)};
            wstrb_d  = st_wstrb;
            wdata_d  = st_wdata_sh;
            we_d     = req_we;
            funct3_d = req_funct3;
            rd_d     = req_rd;
            off_d    = req_addr[OW-1:0];
          end
        end
      end
      REQ: begin
        if (mem_ready) state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_result;
          resp_rd_d    = rd_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every register resets so the bus and response ports start at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      rd_q         <= '0;
      off_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      off_q        <= off_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign mem_valid  = (state_q == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wdata  = wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed table-driven bench for riscv_lsu at XLEN=32 plus a small XLEN=64 instance.
module tb_riscv_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        fault;
  logic [31:0] fault_addr;
  logic        stall;

  logic        w_req_valid, w_req_ready, w_req_we;
  logic [2:0]  w_req_funct3;
  logic [63:0] w_req_addr, w_req_wdata;
  logic [4:0]  w_req_rd;
  logic        w_mem_valid, w_mem_ready, w_mem_we;
  logic [63:0] w_mem_addr;
  logic [7:0]  w_mem_wstrb;
  logic [63:0] w_mem_wdata;
  logic        w_mem_rvalid;
  logic [63:0] w_mem_rdata;
  logic        w_resp_valid;
  logic [63:0] w_resp_rdata;
  logic [4:0]  w_resp_rd;
  logic        w_fault;
  logic [63:0] w_fault_addr;
  logic        w_stall;

  riscv_lsu #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .fault(fault), .fault_addr(fault_addr), .stall(stall)
  );

  riscv_lsu #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
    .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_rd(w_req_rd),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
    .mem_wstrb(w_mem_wstrb), .mem_wdata(w_mem_wdata), .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
    .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_rd(w_resp_rd),
    .fault(w_fault), .fault_addr(w_fault_addr), .stall(w_stall)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        exp_fault;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                              input logic [4:0] tag, input logic ef, input logic [3:0] es,
                              input logic [31:0] ew, input logic [31:0] er);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat; v.rd = tag;
    v.exp_fault = ef; v.exp_strb = es; v.exp_wdata = ew; v.exp_rdata = er;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk($sformatf("%s.req_ready", v.name), req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.exp_fault) begin
      chk($sformatf("%s.fault", v.name), fault, 1);
      chk($sformatf("%s.fault_addr", v.name), fault_addr, v.addr);
      chk($sformatf("%s.mem_valid", v.name), mem_valid, 0);
      chk($sformatf("%s.stall", v.name), stall, 0);
      @(posedge clk); #1;
      chk($sformatf("%s.fault_pulse", v.name), fault, 0);
      chk($sformatf("%s.mem_valid2", v.name), mem_valid, 0);
    end else begin
      chk($sformatf("%s.mem_valid", v.name), mem_valid, 1);
      chk($sformatf("%s.stall", v.name), stall, 1);
      chk($sformatf("%s.mem_we", v.name), mem_we, v.we);
      chk($sformatf("%s.mem_addr", v.name), mem_addr, v.addr & 32'hFFFF_FFFC);
      if (v.we) begin
        chk($sformatf("%s.mem_wstrb", v.name), mem_wstrb, v.exp_strb);
        chk($sformatf("%s.mem_wdata", v.name), mem_wdata, v.exp_wdata);
        @(posedge clk); #1;
        chk($sformatf("%s.done_valid", v.name), mem_valid, 0);
        chk($sformatf("%s.done_stall", v.name), stall, 0);
        chk($sformatf("%s.done_ready", v.name), req_ready, 1);
      end else begin
        @(posedge clk); #1;
        chk($sformatf("%s.wait_valid", v.name), mem_valid, 0);
        chk($sformatf("%s.wait_stall", v.name), stall, 1);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk($sformatf("%s.resp_valid", v.name), resp_valid, 1);
        chk($sformatf("%s.resp_rdata", v.name), resp_rdata, v.exp_rdata);
        chk($sformatf("%s.resp_rd", v.name), resp_rd, v.rd);
        chk($sformatf("%s.resp_stall", v.name), stall, 0);
        @(posedge clk); #1;
        chk($sformatf("%s.resp_pulse", v.name), resp_valid, 0);
      end
    end
  endtask

  task automatic run64(input string n, input logic we, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rdat, input logic [7:0] es,
                       input logic [63:0] er);
    @(negedge clk);
    w_req_valid = 1'b1; w_req_we = we; w_req_funct3 = f3;
    w_req_addr = a; w_req_wdata = wd; w_req_rd = 5'd9;
    @(posedge clk); #1;
    w_req_valid = 1'b0;
    chk($sformatf("%s.mem_valid", n), w_mem_valid, 1);
    chk($sformatf("%s.mem_addr", n), w_mem_addr, a & 64'hFFFF_FFFF_FFFF_FFF8);
    if (we) begin
      chk($sformatf("%s.mem_wstrb", n), w_mem_wstrb, es);
      chk($sformatf("%s.mem_wdata", n), w_mem_wdata, wd);
      @(posedge clk); #1;
      chk($sformatf("%s.done_ready", n), w_req_ready, 1);
    end else begin
      @(posedge clk); #1;
      w_mem_rvalid = 1'b1; w_mem_rdata = rdat;
      @(posedge clk); #1;
      w_mem_rvalid = 1'b0;
      chk($sformatf("%s.resp_valid", n), w_resp_valid, 1);
      chk($sformatf("%s.resp_rdata", n), w_resp_rdata, er);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    w_req_valid = 0; w_req_we = 0; w_req_funct3 = 0; w_req_addr = 0; w_req_wdata = 0; w_req_rd = 0;
    w_mem_ready = 1; w_mem_rvalid = 0; w_mem_rdata = 0;

    vecs[0]  = mk("sb_1003",  1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, 0, 4'b1000, 32'hAB00_0000, 0);
    vecs[1]  = mk("lb_2002",  0, 3'b000, 32'h2002, 0, 32'h0080_7F00, 5'd7, 0, 0, 0, 32'hFFFF_FF80);
    vecs[2]  = mk("lbu_2002", 0, 3'b100, 32'h2002, 0, 32'h0080_7F00, 5'd12, 0, 0, 0, 32'h0000_0080);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[3]  = mk("lh_3001",  0, 3'b001, 32'h3001, 0, 32'hAABB_CCDD, 5'd3, 1, 0, 0, 0);
    vecs[4]  = mk("sw_8003",  1, 3'b010, 32'h8003, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk("lw_9002",  0, 3'b010, 32'h9002, 0, 32'h1122_3344, 5'd4, 1, 0, 0, 0);
`else
    vecs[3]  = mk("lh_3001",  0, 3'b001, 32'h3001, 0, 32'hAABB_CCDD, 5'd3, 0, 0, 0, 32'hFFFF_BBCC);
    vecs[4]  = mk("sw_8003",  1, 3'b010, 32'h8003, 32'hDEAD_BEEF, 0, 0, 0, 4'b1000, 32'hEF00_0000, 0);
    vecs[5]  = mk("lw_9002",  0, 3'b010, 32'h9002, 0, 32'h1122_3344, 5'd4, 0, 0, 0, 32'h0000_1122);
`endif
    vecs[6]  = mk("sh_4002",  1, 3'b001, 32'h4002, 32'h0000_1234, 0, 0, 0, 4'b1100, 32'h1234_0000, 0);
    vecs[7]  = mk("lw_5000",  0, 3'b010, 32'h5000, 0, 32'h8000_0001, 5'd31, 0, 0, 0, 32'h8000_0001);
    vecs[8]  = mk("lhu_6002", 0, 3'b101, 32'h6002, 0, 32'h8765_4321, 5'd1, 0, 0, 0, 32'h0000_8765);
    vecs[9]  = mk("lh_6002",  0, 3'b001, 32'h6002, 0, 32'h8765_4321, 5'd2, 0, 0, 0, 32'hFFFF_8765);
    vecs[10] = mk("ld_0018",  0, 3'b011, 32'h0018, 0, 0, 5'd5, 1, 0, 0, 0);
    vecs[11] = mk("sbu_0020", 1, 3'b100, 32'h0020, 32'h55, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk("f111_0030", 0, 3'b111, 32'h0030, 0, 0, 5'd6, 1, 0, 0, 0);
    vecs[13] = mk("sw_7000",  1, 3'b010, 32'h7000, 32'hDEAD_BEEF, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.stall", stall, 0);
    chk("rst.mem_valid", mem_valid, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wstrb", mem_wstrb, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.resp_rd", resp_rd, 0);
    chk("rst.fault", fault, 0);
    chk("rst.fault_addr", fault_addr, 0);
    chk("rst64.wstrb", w_mem_wstrb, 0);
    reset = 1'b0;

    mem_ready = 1'b1;
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Store held off by mem_ready for three cycles.
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h7004; req_wdata = 32'hCAFE_F00D; req_rd = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1'b1;
      chk($sformatf("sw_hold%0d.mem_valid", c), mem_valid, 1);
      chk($sformatf("sw_hold%0d.mem_addr", c), mem_addr, 32'h7004);
      chk($sformatf("sw_hold%0d.mem_wstrb", c), mem_wstrb, 4'b1111);
      chk($sformatf("sw_hold%0d.mem_wdata", c), mem_wdata, 32'hCAFE_F00D);
      chk($sformatf("sw_hold%0d.req_ready", c), req_ready, 0);
      chk($sformatf("sw_hold%0d.stall", c), stall, 1);
      @(posedge clk); #1;
    end
    chk("sw_hold.end_ready", req_ready, 1);
    chk("sw_hold.end_valid", mem_valid, 0);

    // Reset while in REQ drops mem_valid without a clock edge.
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0100; req_rd = 5'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_req.mem_valid_before", mem_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_req.mem_valid", mem_valid, 0);
    chk("rst_req.stall", stall, 0);
    chk("rst_req.req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Reset while in WAIT; a late mem_rvalid must produce nothing.
    mem_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0200; req_rd = 5'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait.stall_before", stall, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait.stall", stall, 0);
    chk("rst_wait.resp_valid", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_wait.late%0d.resp_valid", c), resp_valid, 0);
      chk($sformatf("rst_wait.late%0d.req_ready", c), req_ready, 1);
      chk($sformatf("rst_wait.late%0d.mem_valid", c), mem_valid, 0);
    end
    mem_rvalid = 1'b0;

    // Reset while resp_valid is high clears it asynchronously.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0300; req_rd = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0042;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rst_resp.resp_valid_before", resp_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_resp.resp_valid", resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    run64("sd_0018",  1, 3'b011, 64'h18, 64'h1122_3344_5566_7788, 0, 8'hFF, 0);
    run64("lw64_001c", 0, 3'b010, 64'h1C, 0, 64'h8000_0000_1234_5678, 0, 64'hFFFF_FFFF_8000_0000);
    run64("lwu64_001c", 0, 3'b110, 64'h1C, 0, 64'h8000_0000_1234_5678, 0, 64'h0000_0000_8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
